// File: rtl/run_length_encoder.sv
// run_length_encoder
//   Turns a streamed binary mask (one pixel per clock while pix_valid) into
//   run records {row, start column, end column} plus one end-of-line record
//   per row. Records pass through a small first-word-fall-through FIFO so the
//   downstream blob labeller can stall via run_ready.
//
// Ports
//   VGA_IN_DATA_CLK  pixel clock, rising edge
//   rst_n            asynchronous active-low reset
//   frame_start      pulse before the first row of a frame
//   line_start       pulse before the first pixel of each row
//   pix_valid        pix_mask carries an active pixel this cycle
//   pix_mask         mask value of the current pixel
//   run_valid        FIFO head is valid
//   run_ready        consumer accepts the head
//   run_start        start column of the head (all-ones for EOL)
//   run_end          inclusive end column of the head (all-ones for EOL)
//   run_row          row of the head record
//   run_eol          head is an end-of-line record
//   fifo_level       current FIFO occupancy
//   overflow         sticky: a record was lost to a full FIFO
//   row_trunc        sticky: a row hit MAX_RUNS
module run_length_encoder #(
  parameter int COL_W      = 11,
  parameter int ROW_W      = 11,
  parameter int WIDTH      = 1024,
  parameter int MAX_RUNS   = 512,
  parameter int MIN_RUN    = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          VGA_IN_DATA_CLK,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          line_start,
  input  logic                          pix_valid,
  input  logic                          pix_mask,
  output logic                          run_valid,
  input  logic                          run_ready,
  output logic [COL_W-1:0]              run_start,
  output logic [COL_W-1:0]              run_end,
  output logic [ROW_W-1:0]              run_row,
  output logic                          run_eol,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          row_trunc
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = $clog2(MAX_RUNS + 1);
  localparam int REC_W = ROW_W + 2 * COL_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_EOL  = 2'd3;

  localparam logic [COL_W-1:0] END_MARK = '1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [COL_W:0]   MIN_LEN  = (COL_W + 1)'(MIN_RUN);
  localparam logic [CNT_W-1:0] RUN_CAP  = CNT_W'(MAX_RUNS);
  localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);

  logic [1:0]       state;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] start_col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] run_cnt;

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             overflow_flag;
  logic             trunc_flag;

  // Run-closing and push decisions for the current cycle
  logic             pixel_take;
  logic             last_pix;
  logic             close_run;
  logic [COL_W-1:0] close_start;
  logic [COL_W-1:0] close_end;
  logic [COL_W:0]   run_len;
  logic             len_ok;
  logic             push_run;
  logic             push_eol;
  logic             trunc_hit;
  logic             push;
  logic [REC_W-1:0] push_data;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             drop;
  logic [REC_W-1:0] head;

  always_comb begin
    pixel_take  = 1'b0;
    last_pix    = 1'b0;
    close_run   = 1'b0;
    close_start = start_col;
    close_end   = col - COL_W'(1);
    pixel_take  = pix_valid && (state == S_GAP || state == S_RUN);
    last_pix    = pixel_take && (col == LAST_COL);
    if (pixel_take && state == S_RUN && !pix_mask) begin
      close_run = 1'b1;
    end else if (last_pix && pix_mask) begin
      // A run still open on the last pixel closes at the row edge; a run
      // that starts there is a single pixel wide.
      close_run   = 1'b1;
      close_start = (state == S_RUN) ? start_col : col;
      close_end   = LAST_COL;
    end
    run_len = {1'b0, close_end} - {1'b0, close_start} + (COL_W + 1)'(1);
    len_ok  = run_len >= MIN_LEN;
    // frame_start and line_start both abandon whatever the FSM was doing
    push_run  = close_run && len_ok && (run_cnt < RUN_CAP) && !frame_start && !line_start;
    trunc_hit = close_run && len_ok && !(run_cnt < RUN_CAP) && !frame_start && !line_start;
    push_eol  = (state == S_EOL) && !frame_start && !line_start;
    push      = push_run || push_eol;
    if (push_eol) begin
      push_data = {row, END_MARK, END_MARK, 1'b1};
    end else begin
      push_data = {row, close_start, close_end, 1'b0};
    end
  end

  assign run_valid = (level != '0);
  assign full      = (level == FULL_LVL);
  assign pop       = run_valid && run_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge VGA_IN_DATA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      col           <= '0;
      start_col     <= '0;
      row           <= '0;
      run_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow_flag <= 1'b0;
      trunc_flag    <= 1'b0;
    end else begin
      if (frame_start) begin
        state <= S_IDLE;
        row   <= '0;
      end else if (line_start) begin
        state   <= S_GAP;
        col     <= '0;
        run_cnt <= '0;
      end else begin
        case (state)
          S_GAP, S_RUN: begin
            if (pix_valid) begin
              col <= col + COL_W'(1);
              if (last_pix) begin
                state <= S_EOL;
              end else if (state == S_GAP && pix_mask) begin
                state     <= S_RUN;
                start_col <= col;
              end else if (state == S_RUN && !pix_mask) begin
                state <= S_GAP;
              end
            end
          end
          S_EOL: begin
            row   <= row + ROW_W'(1);
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end

      if (push_run) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end

      if (frame_start) begin
        overflow_flag <= 1'b0;
        trunc_flag    <= 1'b0;
      end else begin
        if (drop) begin
          overflow_flag <= 1'b1;
        end
        if (trunc_hit) begin
          trunc_flag <= 1'b1;
        end
      end

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge VGA_IN_DATA_CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head       = mem[rd_ptr];
  assign run_row    = run_valid ? head[REC_W-1 -: ROW_W] : '0;
  assign run_start  = run_valid ? head[2*COL_W -: COL_W] : '0;
  assign run_end    = run_valid ? head[COL_W -: COL_W] : '0;
  assign run_eol    = run_valid ? head[0] : 1'b0;
  assign fifo_level = level;
  assign overflow   = overflow_flag;
  assign row_trunc  = trunc_flag;

endmodule

// File: tb/tb_run_length_encoder.sv
// tb_run_length_encoder
//   Drives rows of mask pixels (directed and $urandom) into a narrow
//   run_length_encoder and compares every output each cycle against a
//   reference built from whole-row run lists and a record queue.
module tb_run_length_encoder;

  localparam int COL_W = 11;
  localparam int ROW_W = 11;
  localparam int W     = 64;
  localparam int MAXR  = 4;
  localparam int MINR  = 3;
  localparam int DEPTH = 4;
  localparam int MARK  = 2047;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             line_start = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_mask = 1'b0;
  logic             run_ready = 1'b0;
  logic             run_valid;
  logic [COL_W-1:0] run_start;
  logic [COL_W-1:0] run_end;
  logic [ROW_W-1:0] run_row;
  logic             run_eol;
  logic [2:0]       fifo_level;
  logic             overflow;
  logic             row_trunc;

  run_length_encoder #(
    .COL_W(COL_W), .ROW_W(ROW_W), .WIDTH(W), .MAX_RUNS(MAXR),
    .MIN_RUN(MINR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .VGA_IN_DATA_CLK(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .line_start(line_start),
    .pix_valid(pix_valid),
    .pix_mask(pix_mask),
    .run_valid(run_valid),
    .run_ready(run_ready),
    .run_start(run_start),
    .run_end(run_end),
    .run_row(run_row),
    .run_eol(run_eol),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .row_trunc(row_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int s;
    int e;
    bit eol;
  } rec_t;

  rec_t q[$];
  int   m_row;
  bit   m_ovf;
  bit   m_trunc;
  bit   mrow [W];
  int   n_checks;
  int   n_fail;
  int   cycle_no;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cycle_no, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("run_valid", int'(run_valid), int'(q.size() != 0));
    check("fifo_level", int'(fifo_level), q.size());
    check("overflow", int'(overflow), int'(m_ovf));
    check("row_trunc", int'(row_trunc), int'(m_trunc));
    if (q.size() != 0) begin
      check("run_start", int'(run_start), q[0].s);
      check("run_end", int'(run_end), q[0].e);
      check("run_row", int'(run_row), q[0].row);
      check("run_eol", int'(run_eol), int'(q[0].eol));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(run_valid), 0);
    check({tag, "_start"}, int'(run_start), 0);
    check({tag, "_end"}, int'(run_end), 0);
    check({tag, "_row"}, int'(run_row), 0);
    check({tag, "_eol"}, int'(run_eol), 0);
    check({tag, "_level"}, int'(fifo_level), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_trunc"}, int'(row_trunc), 0);
  endtask

  // mode 0: never ready, 1: random, 2: always ready
  task automatic set_ready(input int mode);
    case (mode)
      0:       run_ready = 1'b0;
      1:       run_ready = ($urandom_range(1) == 1);
      default: run_ready = 1'b1;
    endcase
  endtask

  // Inputs for this cycle are already driven; advance the queue model by one
  // clock edge, then compare at the following falling edge.
  task automatic step(input bit push, input rec_t r);
    bit pop;
    bit full;
    pop  = (q.size() != 0) && run_ready;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1'b1;
      else q.push_back(r);
    end
    @(negedge clk);
    cycle_no++;
    compare_outputs();
  endtask

  task automatic idle(input int n, input int mode);
    rec_t none;
    none = '{0, 0, 0, 1'b0};
    pix_valid = 1'b0;
    repeat (n) begin
      set_ready(mode);
      step(1'b0, none);
    end
  endtask

  task automatic pulse_frame();
    rec_t none;
    none = '{0, 0, 0, 1'b0};
    frame_start = 1'b1;
    set_ready(2);
    m_row = 0;
    m_ovf = 1'b0;
    m_trunc = 1'b0;
    step(1'b0, none);
    frame_start = 1'b0;
  endtask

  // Sends mrow as one row. Runs are found over the whole row first; each one
  // becomes visible at the pixel that closes it (end+1, or the last pixel).
  task automatic drive_row(input int mode, input int abort_at);
    bit   has_close [W];
    int   cs [W];
    int   ce [W];
    int   kept;
    int   s;
    int   c;
    rec_t r;
    rec_t none;
    none = '{0, 0, 0, 1'b0};
    for (int i = 0; i < W; i++) has_close[i] = 1'b0;
    s = 0;
    for (int i = 0; i < W; i++) begin
      if (mrow[i] && (i == 0 || !mrow[i-1])) s = i;
      if (mrow[i] && (i == W - 1 || !mrow[i+1])) begin
        c = (i == W - 1) ? i : i + 1;
        has_close[c] = 1'b1;
        cs[c] = s;
        ce[c] = i;
      end
    end
    kept = 0;
    line_start = 1'b1;
    pix_valid = 1'b0;
    set_ready(mode);
    step(1'b0, none);
    line_start = 1'b0;
    for (int i = 0; i < W; i++) begin
      while ($urandom_range(3) == 0) begin
        pix_valid = 1'b0;
        set_ready(mode);
        step(1'b0, none);
      end
      if (i == abort_at) begin
        pix_valid = 1'b0;
        pulse_frame();
        return;
      end
      pix_valid = 1'b1;
      pix_mask = mrow[i];
      set_ready(mode);
      if (has_close[i] && (ce[i] - cs[i] + 1) >= MINR) begin
        if (kept < MAXR) begin
          kept++;
          r = '{m_row, cs[i], ce[i], 1'b0};
          step(1'b1, r);
        end else begin
          m_trunc = 1'b1;
          step(1'b0, none);
        end
      end else begin
        step(1'b0, none);
      end
    end
    pix_valid = 1'b0;
    pix_mask = 1'b0;
    set_ready(mode);
    r = '{m_row, MARK, MARK, 1'b1};
    step(1'b1, r);
    m_row = (m_row + 1) % (1 << ROW_W);
  endtask

  task automatic clear_row();
    for (int i = 0; i < W; i++) mrow[i] = 1'b0;
  endtask

  task automatic set_span(input int a, input int b);
    for (int i = a; i <= b; i++) mrow[i] = 1'b1;
  endtask

  task automatic random_row();
    bit cur;
    cur = 1'b0;
    for (int i = 0; i < W; i++) begin
      if ($urandom_range(3) == 0) cur = ~cur;
      mrow[i] = cur;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cycle_no = 0;
    m_row = 0;
    m_ovf = 1'b0;
    m_trunc = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    compare_outputs();
    pulse_frame();

    // Two runs, always ready
    clear_row();
    set_span(10, 19);
    set_span(40, 42);
    drive_row(2, -1);
    idle(3, 2);

    // Too-short run filtered, run touching the last column
    clear_row();
    set_span(5, 6);
    set_span(9, 11);
    set_span(W - 4, W - 1);
    drive_row(2, -1);
    idle(3, 2);

    // Six qualifying runs: only MAXR survive, row_trunc sticks
    clear_row();
    for (int k = 0; k < 6; k++) set_span(2 + 6 * k, 4 + 6 * k);
    drive_row(2, -1);
    idle(3, 2);
    clear_row();
    set_span(30, 33);
    drive_row(2, -1);
    idle(3, 2);

    // Consumer stalled: FIFO fills, EOL lost, heads held, then drain
    pulse_frame();
    clear_row();
    for (int k = 0; k < 6; k++) set_span(2 + 6 * k, 4 + 6 * k);
    drive_row(0, -1);
    idle(5, 0);
    idle(8, 2);

    // Randomised rows with random backpressure
    for (int n = 0; n < 20; n++) begin
      random_row();
      drive_row(1, -1);
      idle($urandom_range(4), 1);
    end
    idle(8, 2);

    // frame_start in the middle of an open run
    clear_row();
    set_span(3, 5);
    set_span(20, W - 1);
    drive_row(2, 30);
    idle(3, 2);
    random_row();
    drive_row(1, -1);
    idle(8, 2);

    // Asynchronous reset while the FIFO holds records
    clear_row();
    for (int k = 0; k < 6; k++) set_span(2 + 6 * k, 4 + 6 * k);
    drive_row(0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    q.delete();
    m_row = 0;
    m_ovf = 1'b0;
    m_trunc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_outputs();
    pulse_frame();
    random_row();
    drive_row(1, -1);
    idle(8, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
